// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: RISC-V load funct3 codes, access sizes and FSM states.
package load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR0 = 3'd1,
    S_DATA0 = 3'd2,
    S_ADDR1 = 3'd3,
    S_DATA1 = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  function automatic logic [3:0] sizeBytes(size_e s);
    case (s)
      SZ_BYTE: return 4'd1;
      SZ_HALF: return 4'd2;
      SZ_WORD: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational result formatter: extracts the addressed bytes from the two captured
// bus words and truncates/extends them according to the load funct3.
module load_align
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata0_i,
  input  logic [XLEN-1:0]              rdata1_i,
  input  logic [$clog2(XLEN/8)-1:0]    offset_i,
  input  logic [2:0]                   funct3_i,
  output logic [XLEN-1:0]              data_o
);

  logic [XLEN-1:0] low;
  logic            zext;

  // Beat 1 sits above beat 0, so a crossing load is a plain right shift of the pair
  assign low  = XLEN'({rdata1_i, rdata0_i} >> {offset_i, 3'b000});
  assign zext = funct3_i[2];

  always_comb begin
    data_o = low;
    case (size_e'(funct3_i[1:0]))
      SZ_BYTE: data_o = zext ? XLEN'(low[7:0])  : XLEN'($signed(low[7:0]));
      SZ_HALF: data_o = zext ? XLEN'(low[15:0]) : XLEN'($signed(low[15:0]));
      SZ_WORD: data_o = zext ? XLEN'(low[31:0]) : XLEN'($signed(low[31:0]));
      default: data_o = low;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RISC-V load unit: decodes a load request, issues one or two aligned bus reads
// (or faults), and returns the aligned, extended result as a single-cycle pulse.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_type,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_exception,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int WB   = XLEN / 8;
  localparam int OFFW = $clog2(WB);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [OFFW-1:0]   offset_q, offset_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              split_q, split_d;
  logic              exc_q, exc_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;

  logic [OFFW-1:0]   reqOffset;
  logic [4:0]        reqEnd;
  logic              reqIllegal;
  logic              reqCross;
  logic              reqFault;
  logic [XLEN-1:0]   reqAligned;
  logic [XLEN-1:0]   alignData;

  // Request decode; LD and LWU only exist on 64-bit machines
  assign reqOffset  = req_addr[OFFW-1:0];
  assign reqEnd     = 5'(reqOffset) + 5'(sizeBytes(size_e'(req_type[1:0])));
  assign reqCross   = reqEnd > 5'(WB);
  assign reqIllegal = (req_type == F3_BAD) ||
                      ((XLEN == 32) && ((req_type == F3_LD) || (req_type == F3_LWU)));
  assign reqFault   = reqIllegal || (reqCross && !SPLIT_MISALIGNED);
  assign reqAligned = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  load_align #(.XLEN(XLEN)) u_align (
    .rdata0_i (rdata0_q),
    .rdata1_i (rdata1_q),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (alignData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      offset_q <= '0;
      funct3_q <= '0;
      split_q  <= 1'b0;
      exc_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      offset_q <= offset_d;
      funct3_q <= funct3_d;
      split_q  <= split_d;
      exc_q    <= exc_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    offset_d   = offset_q;
    funct3_d   = funct3_q;
    split_d    = split_q;
    exc_d      = exc_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = req_type;
          offset_d = reqOffset;
          addr_d   = reqAligned;
          split_d  = reqCross;
          exc_d    = reqFault;
          rdata0_d = '0;
          rdata1_d = '0;
          state_d  = reqFault ? S_RESP : S_ADDR0;
        end
      end
      S_ADDR0: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = S_DATA0;
      end
      S_DATA0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
          if (split_q) begin
            // Second beat reads the next word; wrapping past the top of memory is intended
            addr_d  = addr_q + XLEN'(WB);
            state_d = S_ADDR1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_ADDR1: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = S_DATA1;
      end
      S_DATA1: begin
        if (mem_rvalid) begin
          rdata1_d = mem_rdata;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr       = mem_valid ? addr_q : '0;
  assign resp_exception = (state_q == S_RESP) && exc_q;
  assign resp_data      = ((state_q == S_RESP) && !exc_q) ? alignData : '0;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: three instances (32-bit split, 32-bit no-split, 64-bit split)
// driven by a cycle-accurate bus responder task with hand-computed expectations.
module tb_load_unit;

  logic        clk;
  logic        rst;
  logic        reqValid  [3];
  logic [2:0]  reqType   [3];
  logic [63:0] reqAddr   [3];
  logic        memReady  [3];
  logic        memRvalid [3];
  logic [63:0] memRdata  [3];

  logic        reqReady  [3];
  logic        respValid [3];
  logic        respExc   [3];
  logic        memValid  [3];
  logic [63:0] respData  [3];
  logic [63:0] memAddr   [3];

  logic [31:0] u0RespData, u0MemAddr, u1RespData, u1MemAddr;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_type(reqType[0]),
    .req_addr(reqAddr[0][31:0]),
    .resp_valid(respValid[0]), .resp_data(u0RespData), .resp_exception(respExc[0]),
    .mem_valid(memValid[0]), .mem_ready(memReady[0]), .mem_addr(u0MemAddr),
    .mem_rvalid(memRvalid[0]), .mem_rdata(memRdata[0][31:0])
  );

  load_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_type(reqType[1]),
    .req_addr(reqAddr[1][31:0]),
    .resp_valid(respValid[1]), .resp_data(u1RespData), .resp_exception(respExc[1]),
    .mem_valid(memValid[1]), .mem_ready(memReady[1]), .mem_addr(u1MemAddr),
    .mem_rvalid(memRvalid[1]), .mem_rdata(memRdata[1][31:0])
  );

  load_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_type(reqType[2]),
    .req_addr(reqAddr[2]),
    .resp_valid(respValid[2]), .resp_data(respData[2]), .resp_exception(respExc[2]),
    .mem_valid(memValid[2]), .mem_ready(memReady[2]), .mem_addr(memAddr[2]),
    .mem_rvalid(memRvalid[2]), .mem_rdata(memRdata[2])
  );

  assign respData[0] = {32'd0, u0RespData};
  assign memAddr[0]  = {32'd0, u0MemAddr};
  assign respData[1] = {32'd0, u1RespData};
  assign memAddr[1]  = {32'd0, u1MemAddr};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One load on instance u; the bus accepts immediately once 'stall' refusals are used up
  // and returns data the cycle after each handshake. Latency counts cycles after the accept edge.
  task automatic applyStimulus(
    input  int          u,
    input  logic [2:0]  t,
    input  logic [63:0] addr,
    input  logic [63:0] d0,
    input  logic [63:0] d1,
    input  int          stall,
    output logic [63:0] data,
    output logic        exc,
    output int          lat,
    output int          beats,
    output logic [63:0] a0,
    output logic [63:0] a1,
    output logic        stable,
    output logic        respAfter,
    output logic        readyAfter
  );
    logic        pend;
    logic        heldValid;
    logic [63:0] held;
    int          stallLeft;
    data = '0; exc = 1'b0; lat = 0; beats = 0; a0 = '0; a1 = '0;
    stable = 1'b1; pend = 1'b0; heldValid = 1'b0; held = '0; stallLeft = stall;
    @(negedge clk);
    reqValid[u] = 1'b1;
    reqType[u]  = t;
    reqAddr[u]  = addr;
    @(posedge clk);
    #1 reqValid[u] = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      memRvalid[u] = 1'b0;
      if (pend) begin
        memRvalid[u] = 1'b1;
        memRdata[u]  = (beats == 1) ? d0 : d1;
        pend = 1'b0;
      end
      if (respValid[u]) begin
        lat  = k;
        data = respData[u];
        exc  = respExc[u];
      end
      if (memValid[u]) begin
        if (heldValid && memAddr[u] !== held) stable = 1'b0;
        held = memAddr[u];
        heldValid = 1'b1;
        if (stallLeft > 0) begin
          memReady[u] = 1'b0;
          stallLeft--;
        end else begin
          memReady[u] = 1'b1;
          if (beats == 0) a0 = memAddr[u];
          else a1 = memAddr[u];
          beats++;
          pend = 1'b1;
          heldValid = 1'b0;
        end
      end else begin
        memReady[u] = 1'b0;
      end
    end
    memReady[u]  = 1'b0;
    memRvalid[u] = 1'b0;
    @(negedge clk);
    respAfter  = respValid[u];
    readyAfter = reqReady[u];
  endtask

  task automatic expectLoad(
    input string       tag,
    input int          u,
    input logic [2:0]  t,
    input logic [63:0] addr,
    input logic [63:0] d0,
    input logic [63:0] d1,
    input int          stall,
    input logic [63:0] eData,
    input logic        eExc,
    input int          eLat,
    input int          eBeats,
    input logic [63:0] eA0,
    input logic [63:0] eA1
  );
    logic [63:0] data, a0, a1;
    logic        exc, stable, respAfter, readyAfter;
    int          lat, beats;
    applyStimulus(u, t, addr, d0, d1, stall, data, exc, lat, beats, a0, a1,
                  stable, respAfter, readyAfter);
    checkOutput({tag, ".data"},  data, eData);
    checkOutput({tag, ".exc"},   64'(exc), 64'(eExc));
    checkOutput({tag, ".lat"},   64'(lat), 64'(eLat));
    checkOutput({tag, ".beats"}, 64'(beats), 64'(eBeats));
    if (eBeats > 0) checkOutput({tag, ".addr0"}, a0, eA0);
    if (eBeats > 1) checkOutput({tag, ".addr1"}, a1, eA1);
    if (stall > 0)  checkOutput({tag, ".stable"}, 64'(stable), 64'd1);
    checkOutput({tag, ".pulse"}, 64'(respAfter), 64'd0);
    checkOutput({tag, ".ready"}, 64'(readyAfter), 64'd1);
  endtask

  initial begin
    int seen;
    for (int u = 0; u < 3; u++) begin
      reqValid[u] = 1'b0; reqType[u] = 3'b000; reqAddr[u] = '0;
      memReady[u] = 1'b0; memRvalid[u] = 1'b0; memRdata[u] = '0;
    end
    rst = 1'b1;
    #12;
    for (int u = 0; u < 3; u++) begin
      checkOutput($sformatf("rst%0d.ready", u), 64'(reqReady[u]), 64'd1);
      checkOutput($sformatf("rst%0d.resp", u),  64'(respValid[u]), 64'd0);
      checkOutput($sformatf("rst%0d.data", u),  respData[u], 64'd0);
      checkOutput($sformatf("rst%0d.exc", u),   64'(respExc[u]), 64'd0);
      checkOutput($sformatf("rst%0d.mvalid", u), 64'(memValid[u]), 64'd0);
      checkOutput($sformatf("rst%0d.maddr", u), memAddr[u], 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Stray read data while idle must not produce anything
    @(negedge clk);
    memRvalid[0] = 1'b1; memRdata[0] = 64'hDEAD_BEEF;
    @(negedge clk);
    memRvalid[0] = 1'b0;
    checkOutput("stray.resp", 64'(respValid[0]), 64'd0);
    checkOutput("stray.ready", 64'(reqReady[0]), 64'd1);

    $display("[TB] 32-bit split instance");
    expectLoad("lb3",   0, 3'b000, 64'h3, 64'hBF00_0000, 64'h0, 0, 64'hFFFF_FFBF, 1'b0, 3, 1, 64'h0, 64'h0);
    expectLoad("lhu1",  0, 3'b101, 64'h1, 64'h00FF_FF00, 64'h0, 0, 64'h0000_FFFF, 1'b0, 3, 1, 64'h0, 64'h0);
    expectLoad("lw6",   0, 3'b010, 64'h6, 64'hBBAA_0000, 64'h0000_DDCC, 0, 64'hDDCC_BBAA, 1'b0, 5, 2, 64'h4, 64'h8);
    expectLoad("lbu2",  0, 3'b100, 64'h102, 64'h1234_5678, 64'h0, 0, 64'h0000_0034, 1'b0, 3, 1, 64'h100, 64'h0);
    expectLoad("lh2",   0, 3'b001, 64'h2, 64'h8000_1234, 64'h0, 0, 64'hFFFF_8000, 1'b0, 3, 1, 64'h0, 64'h0);
    expectLoad("ld32",  0, 3'b011, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    expectLoad("lwu32", 0, 3'b110, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    expectLoad("stall", 0, 3'b010, 64'h10, 64'hCAFE_F00D, 64'h0, 3, 64'hCAFE_F00D, 1'b0, 6, 1, 64'h10, 64'h0);

    $display("[TB] 32-bit no-split instance");
    expectLoad("ns.lh3", 1, 3'b001, 64'h3, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    expectLoad("ns.ld",  1, 3'b011, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    expectLoad("ns.bad", 1, 3'b111, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);
    expectLoad("ns.lh1", 1, 3'b001, 64'h1, 64'h00AB_CD00, 64'h0, 0, 64'hFFFF_ABCD, 1'b0, 3, 1, 64'h0, 64'h0);

    $display("[TB] 64-bit split instance");
    expectLoad("ld.wrap", 2, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h89AB_CDEF_0000_0000,
               64'h0000_0000_0123_4567, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 2,
               64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    expectLoad("lwu4", 2, 3'b110, 64'h4, 64'h8000_0000_0000_0000, 64'h0, 0,
               64'h0000_0000_8000_0000, 1'b0, 3, 1, 64'h0, 64'h0);
    expectLoad("lw4",  2, 3'b010, 64'h4, 64'h8000_0000_0000_0000, 64'h0, 0,
               64'hFFFF_FFFF_8000_0000, 1'b0, 3, 1, 64'h0, 64'h0);
    expectLoad("bad64", 2, 3'b111, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0);

    $display("[TB] reset in the middle of a load");
    @(negedge clk);
    reqValid[0] = 1'b1; reqType[0] = 3'b010; reqAddr[0] = 64'h20; memReady[0] = 1'b0;
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d.mvalid", k), 64'(memValid[0]), 64'd1);
      checkOutput($sformatf("hold%0d.maddr", k), memAddr[0], 64'h20);
    end
    @(negedge clk);
    memReady[0] = 1'b1;
    @(posedge clk);
    #1 memReady[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.ready", 64'(reqReady[0]), 64'd1);
    checkOutput("arst.mvalid", 64'(memValid[0]), 64'd0);
    checkOutput("arst.resp", 64'(respValid[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    memRvalid[0] = 1'b1; memRdata[0] = 64'h1111_2222;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      memRvalid[0] = 1'b0;
      if (respValid[0]) seen++;
    end
    checkOutput("late.resp", 64'(seen), 64'd0);
    checkOutput("late.ready", 64'(reqReady[0]), 64'd1);
    expectLoad("recover", 0, 3'b000, 64'h1, 64'h0000_7F00, 64'h0, 0, 64'h0000_007F, 1'b0, 3, 1, 64'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so a stuck handshake can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter XLEN, default 32; data/address width, legal values 32 or 64; word = XLEN/8 bytes.
REQ-002 Parameter SPLIT_MISALIGNED, default 1; 1 = word-crossing loads split into two bus beats, 0 = word-crossing loads raise exception.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  load request present.
REQ-006 req_ready  out  1  unit idle, request accepted on req_valid&&req_ready.
REQ-007 req_type  in  3  RISC-V load funct3 (LB/LH/LW/LD/LBU/LHU/LWU).
REQ-008 req_addr  in  XLEN  byte address.
REQ-009 resp_valid  out  1  one-cycle result pulse, no backpressure.
REQ-010 resp_data  out  XLEN  extended load result, valid with resp_valid.
REQ-011 resp_exception  out  1  misaligned/illegal load, valid with resp_valid; resp_data = 0 when set.
REQ-012 mem_valid  out  1  bus read request.
REQ-013 mem_ready  in  1  bus accepts request on mem_valid&&mem_ready.
REQ-014 mem_addr  out  XLEN  word-aligned read address (low log2(word) bits zero).
REQ-015 mem_rvalid  in  1  read data returned, at least one cycle after the accepting handshake.
REQ-016 mem_rdata  in  XLEN  little-endian read word.

Function
REQ-017 Size from funct3[1:0] (0 byte, 1 half, 2 word, 3 double); funct3[2]=1 selects zero-extension, else sign-extension.
REQ-018 Illegal: 3'b111 always; 3'b011 and 3'b110 when XLEN=32; illegal requests SHALL issue no bus access and respond with resp_exception=1.
REQ-019 Offset = addr mod word; a load crosses when offset+size > word; non-crossing loads at any offset (e.g. LH offset 1) SHALL succeed in one beat.
REQ-020 Crossing with SPLIT_MISALIGNED=0 SHALL respond with exception, no bus access.
REQ-021 Crossing with SPLIT_MISALIGNED=1 SHALL issue beat 0 at aligned addr, then beat 1 at aligned addr + word (modulo 2^XLEN, wrap allowed).
REQ-022 States IDLE, ADDR0, DATA0, ADDR1, DATA1, RESP; req_ready high only in IDLE.
REQ-023 IDLE->ADDR0 on accept of legal non-faulting request; IDLE->RESP on accept of faulting request.
REQ-024 ADDRn: mem_valid=1, mem_addr stable until mem_ready; on handshake -> DATAn.
REQ-025 DATA0: on mem_rvalid capture data -> ADDR1 if split, else RESP; DATA1: on mem_rvalid capture -> RESP.
REQ-026 RESP: resp_valid=1 for exactly one cycle -> IDLE; next request acceptable the following cycle.
REQ-027 Latency with zero-wait bus (mem_ready=1, rvalid next cycle): accept at T, resp_valid at T+3 single-beat, T+5 split, T+1 faulting.
REQ-028 Result = ({rdata1, rdata0} >> 8*offset) truncated to size then extended to XLEN.
REQ-029 mem_rvalid outside DATA0/DATA1 SHALL be ignored; req_valid while busy SHALL be ignored.

Reset
REQ-030 rst SHALL asynchronously force IDLE; req_ready=1, resp_valid=0, resp_data=0, resp_exception=0, mem_valid=0, mem_addr=0, captured data cleared.
REQ-031 Reset mid-operation SHALL abandon the load with no response; late mem_rvalid after reset SHALL be ignored.

Structure
REQ-032 Package load_unit_pkg SHALL hold funct3 constants, size enum and state enum.
REQ-033 One combinational sub-module load_align SHALL perform shift, truncate and extension from {rdata1, rdata0}, offset and funct3.

Verification
REQ-034 XLEN=32, LB addr 0x3, rdata 0xBF000000 -> resp_data 0xFFFFFFBF, exception 0, one bus beat at 0x0.
REQ-035 XLEN=32, LHU addr 0x1, rdata 0x00FFFF00 -> resp_data 0x0000FFFF, exception 0, one beat.
REQ-036 XLEN=32 SPLIT=1, LW addr 0x6, beat0 @0x4 rdata 0xBBAA0000, beat1 @0x8 rdata 0x0000DDCC -> resp_data 0xDDCCBBAA, resp at T+5 zero-wait.
REQ-037 XLEN=32 SPLIT=0, LH addr 0x3 -> resp_exception 1 at T+1, mem_valid never asserted; funct3 3'b011 -> exception likewise.
REQ-038 XLEN=64, LD addr 0xFFFFFFFFFFFFFFFC split -> beat1 mem_addr 0x0 (wrap); LWU addr 0x4 rdata 0x80000000_00000000 -> 0x0000000080000000.
REQ-039 mem_ready held low 3 cycles in ADDR0 with mem_addr stable, then rst asserted in DATA0 -> IDLE immediately, following mem_rvalid ignored, no resp_valid.
